// File: rtl/section_down_timer.sv
// Section down-timer: MM:SS BCD countdown with load/start/pause control,
// a seconds-section borrow strobe and a one-cycle done pulse.
module section_down_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] ld_val,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] count,
  output logic        running,
  output logic        done,
  output logic        bo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] count_nx;
  logic        done_nx;
  logic        bo_nx;
  logic [15:0] dec;
  logic [15:0] load_clamped;
  logic        sec_zero;

  // Limit a BCD digit to the given maximum.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  // Sanitised preset: seconds-tens capped at 5, every other digit at 9.
  always_comb begin
    load_clamped = {clamp_digit(ld_val[15:12], 4'd9),
                    clamp_digit(ld_val[11:8],  4'd9),
                    clamp_digit(ld_val[7:4],   4'd5),
                    clamp_digit(ld_val[3:0],   4'd9)};
  end

  // One-second BCD decrement with borrow ripple across the four digits.
  always_comb begin
    dec      = count;
    sec_zero = (count[7:0] == 8'h00);
    if (count[3:0] != 4'd0) begin
      dec[3:0] = count[3:0] - 4'd1;
    end else begin
      dec[3:0] = 4'd9;
      if (count[7:4] != 4'd0) begin
        dec[7:4] = count[7:4] - 4'd1;
      end else begin
        dec[7:4] = 4'd5;
        if (count[11:8] != 4'd0) begin
          dec[11:8] = count[11:8] - 4'd1;
        end else begin
          dec[11:8]  = 4'd9;
          dec[15:12] = count[15:12] - 4'd1;
        end
      end
    end
  end

  // Next-state logic; command priority is load, then pause, then start.
  // A pause in a non-RUN state still masks start and tick that cycle.
  always_comb begin
    state_nx = state;
    count_nx = count;
    done_nx  = 1'b0;
    bo_nx    = 1'b0;
    if (load) begin
      count_nx = load_clamped;
      state_nx = IDLE;
    end else if (pause) begin
      if (state == RUN) state_nx = PAUSE;
    end else if (start && (state == IDLE || state == PAUSE)) begin
      if (count != '0) state_nx = RUN;
    end else if (tick && state == RUN) begin
      count_nx = dec;
      bo_nx    = sec_zero;
      if (dec == '0) begin
        state_nx = DONE;
        done_nx  = 1'b1;
      end
    end
  end

  // State, count and registered strobes with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
      bo    <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      done  <= done_nx;
      bo    <= bo_nx;
    end
  end

  // running is decoded directly from the state register.
  always_comb begin
    running = (state == RUN);
  end

endmodule

// File: tb/tb_section_down_timer.sv
// Self-checking bench for section_down_timer: per-scenario stimulus tables,
// expected outputs queued as each vector is driven and popped after the edge.
module tb_section_down_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        load;
  logic [15:0] ld_val;
  logic        start;
  logic        pause;
  logic [15:0] count;
  logic        running;
  logic        done;
  logic        bo;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic        rs;
    logic        tk;
    logic        ld;
    logic [15:0] v;
    logic        st;
    logic        ps;
    logic [15:0] c;
    logic        r;
    logic        d;
    logic        b;
  } vec_t;

  logic [18:0] exp_q[$];

  section_down_timer dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .load   (load),
    .ld_val (ld_val),
    .start  (start),
    .pause  (pause),
    .count  (count),
    .running(running),
    .done   (done),
    .bo     (bo)
  );

  always #5 clk = ~clk;

  // Apply one vector for exactly one rising edge; outputs are sampled 1 time unit later.
  task automatic drive(input vec_t s);
    rst    = s.rs;
    tick   = s.tk;
    load   = s.ld;
    ld_val = s.v;
    start  = s.st;
    pause  = s.ps;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rs, input logic tk, input logic ld, input logic [15:0] v,
                              input logic st, input logic ps, input logic [15:0] c,
                              input logic r, input logic d, input logic b);
    vec_t s;
    s = {rs, tk, ld, v, st, ps, c, r, d, b};
    return s;
  endfunction

  task automatic test_reset();
    vec_t t[$];
    logic [18:0] e;
    logic [18:0] o;
    t.push_back(mk(0, 1, 1, 16'h0042, 1, 0, 16'h0000, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0));
    foreach (t[i]) begin
      exp_q.push_back({t[i].c, t[i].r, t[i].d, t[i].b});
      drive(t[i]);
      e = exp_q.pop_front();
      o = {count, running, done, bo};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset[%0d]: got count=%h run=%b done=%b bo=%b, want count=%h run=%b done=%b bo=%b",
                 i, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_countdown();
    vec_t t[$];
    logic [18:0] e;
    logic [18:0] o;
    t.push_back(mk(1, 0, 1, 16'h0003, 0, 0, 16'h0003, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h0003, 1, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0002, 1, 0, 0));
    t.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0002, 1, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 16'h0001, 1, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0));
    t.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0));
    foreach (t[i]) begin
      exp_q.push_back({t[i].c, t[i].r, t[i].d, t[i].b});
      drive(t[i]);
      e = exp_q.pop_front();
      o = {count, running, done, bo};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL countdown[%0d]: got count=%h run=%b done=%b bo=%b, want count=%h run=%b done=%b bo=%b",
                 i, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_borrow();
    vec_t t[$];
    logic [18:0] e;
    logic [18:0] o;
    t.push_back(mk(1, 0, 1, 16'h0100, 0, 0, 16'h0100, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h0100, 1, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0059, 1, 0, 1));
    t.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0059, 1, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0058, 1, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0057, 1, 0, 0));
    foreach (t[i]) begin
      exp_q.push_back({t[i].c, t[i].r, t[i].d, t[i].b});
      drive(t[i]);
      e = exp_q.pop_front();
      o = {count, running, done, bo};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL borrow[%0d]: got count=%h run=%b done=%b bo=%b, want count=%h run=%b done=%b bo=%b",
                 i, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_pause();
    vec_t t[$];
    logic [18:0] e;
    logic [18:0] o;
    t.push_back(mk(1, 0, 1, 16'h1000, 0, 0, 16'h1000, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h1000, 1, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0959, 1, 0, 1));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 16'h0959, 0, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0959, 0, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0959, 0, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 16'h0959, 1, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0958, 1, 0, 0));
    foreach (t[i]) begin
      exp_q.push_back({t[i].c, t[i].r, t[i].d, t[i].b});
      drive(t[i]);
      e = exp_q.pop_front();
      o = {count, running, done, bo};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL pause[%0d]: got count=%h run=%b done=%b bo=%b, want count=%h run=%b done=%b bo=%b",
                 i, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_clamp();
    vec_t t[$];
    logic [18:0] e;
    logic [18:0] o;
    t.push_back(mk(1, 0, 1, 16'h7AF6, 0, 0, 16'h7956, 0, 0, 0));
    t.push_back(mk(1, 0, 1, 16'hFFFF, 0, 0, 16'h9959, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h9959, 1, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h9958, 1, 0, 0));
    t.push_back(mk(1, 1, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0));
    foreach (t[i]) begin
      exp_q.push_back({t[i].c, t[i].r, t[i].d, t[i].b});
      drive(t[i]);
      e = exp_q.pop_front();
      o = {count, running, done, bo};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL clamp[%0d]: got count=%h run=%b done=%b bo=%b, want count=%h run=%b done=%b bo=%b",
                 i, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    vec_t t[$];
    logic [18:0] e;
    logic [18:0] o;
    t.push_back(mk(1, 0, 1, 16'h0530, 0, 0, 16'h0530, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h0530, 1, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0529, 1, 0, 0));
    t.push_back(mk(0, 1, 1, 16'h0044, 1, 1, 16'h0000, 0, 0, 0));
    t.push_back(mk(1, 1, 1, 16'h0005, 0, 0, 16'h0005, 0, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0005, 0, 0, 0));
    foreach (t[i]) begin
      exp_q.push_back({t[i].c, t[i].r, t[i].d, t[i].b});
      drive(t[i]);
      e = exp_q.pop_front();
      o = {count, running, done, bo};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL rst_midrun[%0d]: got count=%h run=%b done=%b bo=%b, want count=%h run=%b done=%b bo=%b",
                 i, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t t[$];
    logic [18:0] e;
    logic [18:0] o;
    t.push_back(mk(1, 0, 1, 16'h0001, 0, 0, 16'h0001, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h0001, 1, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 0));
    t.push_back(mk(1, 0, 1, 16'h0002, 1, 1, 16'h0002, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h0002, 1, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 16'h0001, 1, 0, 0));
    t.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0));
    t.push_back(mk(1, 0, 1, 16'h0010, 0, 0, 16'h0010, 0, 0, 0));
    foreach (t[i]) begin
      exp_q.push_back({t[i].c, t[i].r, t[i].d, t[i].b});
      drive(t[i]);
      e = exp_q.pop_front();
      o = {count, running, done, bo};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got count=%h run=%b done=%b bo=%b, want count=%h run=%b done=%b bo=%b",
                 i, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    rst    = 1'b0;
    tick   = 1'b0;
    load   = 1'b0;
    ld_val = '0;
    start  = 1'b0;
    pause  = 1'b0;
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_clamp();
    test_reset_midrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
